// File: rtl/wbu_arb_pkg.sv
// wbu_pkg: shared widths, request type, grant codes and slot states for wbu_arb
// Widths come from `DATA_WIDTH / `GPRS_WIDTH when the build defines them.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef GPRS_WIDTH
`define GPRS_WIDTH 5
`endif
package wbu_pkg;
  localparam int DATA_W = `DATA_WIDTH;
  localparam int GPRS_W = `GPRS_WIDTH;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_ALU  = 2'b01;
  localparam logic [1:0] GNT_LSU  = 2'b10;
  typedef struct packed {
    logic [GPRS_W-1:0] id;
    logic [DATA_W-1:0] data;
  } wb_req_t;
  typedef enum logic {EMPTY, FULL} slot_st_e;
endpackage

// File: rtl/wbu_arb_if.sv
// wbu_arb_if: producer-side handshakes and GPR write port of the writeback arbiter
// master: EXU/LSU/GPR side (drives requests and i_sys_ready); slave: wbu_arb
interface wbu_arb_if;
  import wbu_pkg::*;
  logic              i_sys_ready;
  logic              i_alu_valid;
  logic              o_alu_ready;
  logic [GPRS_W-1:0] i_alu_wr_id;
  logic [DATA_W-1:0] i_alu_wr_data;
  logic              i_lsu_valid;
  logic              o_lsu_ready;
  logic [GPRS_W-1:0] i_lsu_wr_id;
  logic [DATA_W-1:0] i_lsu_wr_data;
  logic              o_wbu_gpr_wr_en;
  logic [GPRS_W-1:0] o_wbu_gpr_wr_id;
  logic [DATA_W-1:0] o_wbu_gpr_wr_data;
  logic [1:0]        o_arb_gnt;
  logic              o_busy;
  modport master (
    output i_sys_ready, i_alu_valid, i_alu_wr_id, i_alu_wr_data,
    output i_lsu_valid, i_lsu_wr_id, i_lsu_wr_data,
    input  o_alu_ready, o_lsu_ready, o_wbu_gpr_wr_en, o_wbu_gpr_wr_id,
    input  o_wbu_gpr_wr_data, o_arb_gnt, o_busy
  );
  modport slave (
    input  i_sys_ready, i_alu_valid, i_alu_wr_id, i_alu_wr_data,
    input  i_lsu_valid, i_lsu_wr_id, i_lsu_wr_data,
    output o_alu_ready, o_lsu_ready, o_wbu_gpr_wr_en, o_wbu_gpr_wr_id,
    output o_wbu_gpr_wr_data, o_arb_gnt, o_busy
  );
endinterface

// File: rtl/wbu_arb_slot.sv
// wbu_slot: one-entry valid/ready holding register for one writeback producer
// Ports: clk, rst_ni (sync, active-low), valid_i/ready_o/req_i producer handshake,
//        gnt_i arbiter grant (drains the entry), full_o/req_o slot state and contents.
module wbu_slot
  import wbu_pkg::*;
(
  input  logic    clk,
  input  logic    rst_ni,
  input  logic    valid_i,
  output logic    ready_o,
  input  wb_req_t req_i,
  input  logic    gnt_i,
  output logic    full_o,
  output wb_req_t req_o
);
  slot_st_e st_q, st_d;
  wb_req_t  req_q, req_d;
  logic     load;
  // A granted entry leaves this cycle, so the slot can take a new one in the same edge.
  assign ready_o = (st_q == EMPTY) || gnt_i;
  assign load    = valid_i && ready_o;
  assign full_o  = (st_q == FULL);
  assign req_o   = req_q;
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      st_q  <= EMPTY;
      req_q <= '0;
    end else begin
      st_q  <= st_d;
      req_q <= req_d;
    end
  end
  always_comb begin
    st_d  = load ? FULL : (gnt_i ? EMPTY : st_q);
    req_d = load ? req_i : req_q;
  end
endmodule

// File: rtl/wbu_arb.sv
// wbu_arb: arbitrates ALU and LSU writeback slots onto the single registered GPR write port
// Ports: i_sys_clk, i_sys_rst_n (sync, active-low), bus (wbu_arb_if.slave) carrying
//        i_sys_ready, ALU/LSU valid/ready/id/data, registered GPR write, o_arb_gnt, o_busy.
// Config: WBU_ARB_RR_EN selects round-robin on contested cycles; otherwise LSU has fixed priority.
module wbu_arb
  import wbu_pkg::*;
(
  input logic     i_sys_clk,
  input logic     i_sys_rst_n,
  wbu_arb_if.slave bus
);
  wb_req_t           alu_in, lsu_in, alu_req, lsu_req, sel;
  logic              alu_full, lsu_full, gnt_alu, gnt_lsu, lsu_win;
  logic              wr_en_q, wr_en_d;
  logic [GPRS_W-1:0] wr_id_q, wr_id_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [1:0]        gnt_q, gnt_d;
  assign alu_in = {bus.i_alu_wr_id, bus.i_alu_wr_data};
  assign lsu_in = {bus.i_lsu_wr_id, bus.i_lsu_wr_data};
  wbu_slot u_alu (
    .clk    (i_sys_clk),
    .rst_ni (i_sys_rst_n),
    .valid_i(bus.i_alu_valid),
    .ready_o(bus.o_alu_ready),
    .req_i  (alu_in),
    .gnt_i  (gnt_alu),
    .full_o (alu_full),
    .req_o  (alu_req)
  );
  wbu_slot u_lsu (
    .clk    (i_sys_clk),
    .rst_ni (i_sys_rst_n),
    .valid_i(bus.i_lsu_valid),
    .ready_o(bus.o_lsu_ready),
    .req_i  (lsu_in),
    .gnt_i  (gnt_lsu),
    .full_o (lsu_full),
    .req_o  (lsu_req)
  );
`ifdef WBU_ARB_RR_EN
  // rr_q=1: LSU wins the next contested cycle; only contested grants move it.
  logic rr_q, rr_d;
  assign lsu_win = lsu_full && (!alu_full || rr_q);
  assign rr_d    = (bus.i_sys_ready && alu_full && lsu_full) ? gnt_alu : rr_q;
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) rr_q <= 1'b1;
    else rr_q <= rr_d;
  end
`else
  assign lsu_win = lsu_full;
`endif
  assign gnt_lsu = bus.i_sys_ready && lsu_win;
  assign gnt_alu = bus.i_sys_ready && alu_full && !lsu_win;
  // A grant to x0 still consumes the entry but produces no write.
  always_comb begin
    sel       = gnt_lsu ? lsu_req : alu_req;
    wr_en_d   = (gnt_lsu || gnt_alu) && (sel.id != '0);
    wr_id_d   = wr_en_d ? sel.id : '0;
    wr_data_d = wr_en_d ? sel.data : '0;
    gnt_d     = {gnt_lsu, gnt_alu};
  end
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      wr_en_q   <= 1'b0;
      wr_id_q   <= '0;
      wr_data_q <= '0;
      gnt_q     <= GNT_NONE;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_id_q   <= wr_id_d;
      wr_data_q <= wr_data_d;
      gnt_q     <= gnt_d;
    end
  end
  assign bus.o_wbu_gpr_wr_en   = wr_en_q;
  assign bus.o_wbu_gpr_wr_id   = wr_id_q;
  assign bus.o_wbu_gpr_wr_data = wr_data_q;
  assign bus.o_arb_gnt         = gnt_q;
  assign bus.o_busy            = alu_full | lsu_full;
endmodule

// File: tb/tb_wbu_arb.sv
// tb_wbu_arb: self-checking bench for wbu_arb with a queue-based reference model
`timescale 1ns/1ps
module tb_wbu_arb;
  import wbu_pkg::*;
  typedef struct {
    bit rdy; bit av; int unsigned aid; int unsigned ad;
    bit lv; int unsigned lid; int unsigned ld;
    bit e_ar; bit e_lr; bit e_en; int unsigned e_id; int unsigned e_d; int unsigned e_g;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errs = 0;
  int checks = 0;
  wb_req_t aq[$], lq[$];
  bit rr = 1'b1;
  logic m_en = 1'b0;
  logic [GPRS_W-1:0] m_id = '0;
  logic [DATA_W-1:0] m_d = '0;
  logic [1:0] m_g = '0;
  logic s_ar, s_lr;
  vec_t tv[8];
  wbu_arb_if bus();
  wbu_arb dut (.i_sys_clk(clk), .i_sys_rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check readies/busy mid-cycle, advance model at the edge, check registered outputs.
  task automatic cyc(input bit rs, input bit rdy, input bit av, input int unsigned aid,
                     input int unsigned ad, input bit lv, input int unsigned lid, input int unsigned ld);
    int g;
    bit lp, ea, el;
    wb_req_t r;
    rst_n = rs;
    bus.i_sys_ready = rdy;
    bus.i_alu_valid = av;
    bus.i_alu_wr_id = GPRS_W'(aid);
    bus.i_alu_wr_data = DATA_W'(ad);
    bus.i_lsu_valid = lv;
    bus.i_lsu_wr_id = GPRS_W'(lid);
    bus.i_lsu_wr_data = DATA_W'(ld);
    @(negedge clk);
`ifdef WBU_ARB_RR_EN
    lp = rr;
`else
    lp = 1'b1;
`endif
    g = 0;
    if (rdy && lq.size() != 0 && (aq.size() == 0 || lp)) g = 2;
    else if (rdy && aq.size() != 0) g = 1;
    ea = (aq.size() == 0) || (g == 1);
    el = (lq.size() == 0) || (g == 2);
    s_ar = bus.o_alu_ready;
    s_lr = bus.o_lsu_ready;
    chk("alu_ready", s_ar, ea);
    chk("lsu_ready", s_lr, el);
    chk("busy", bus.o_busy, aq.size() != 0 || lq.size() != 0);
    @(posedge clk);
    if (!rs) begin
      aq.delete();
      lq.delete();
      rr = 1'b1;
      m_en = 1'b0; m_id = '0; m_d = '0; m_g = GNT_NONE;
    end else begin
      r = (g == 2) ? lq[0] : ((g == 1) ? aq[0] : '0);
      m_g = (g == 2) ? GNT_LSU : ((g == 1) ? GNT_ALU : GNT_NONE);
      m_en = (g != 0) && (r.id != '0);
      m_id = m_en ? r.id : '0;
      m_d = m_en ? r.data : '0;
      if (g != 0 && aq.size() != 0 && lq.size() != 0) rr = (g == 1);
      if (g == 1) void'(aq.pop_front());
      if (g == 2) void'(lq.pop_front());
      if (av && ea) aq.push_back({GPRS_W'(aid), DATA_W'(ad)});
      if (lv && el) lq.push_back({GPRS_W'(lid), DATA_W'(ld)});
    end
    #1;
    chk("wr_en", bus.o_wbu_gpr_wr_en, m_en);
    chk("wr_id", bus.o_wbu_gpr_wr_id, m_id);
    chk("wr_data", bus.o_wbu_gpr_wr_data, m_d);
    chk("gnt", bus.o_arb_gnt, m_g);
  endtask

  initial begin
    int writes;
    tv[0] = '{1, 1, 5, 'h1234, 0, 0, 0,      1, 1, 0, 0, 0, 0};
    tv[1] = '{1, 0, 0, 0, 0, 0, 0,           1, 1, 1, 5, 'h1234, 1};
    tv[2] = '{1, 1, 3, 'h33, 1, 7, 'h77,     1, 1, 0, 0, 0, 0};
    tv[3] = '{1, 0, 0, 0, 0, 0, 0,           0, 1, 1, 7, 'h77, 2};
    tv[4] = '{1, 0, 0, 0, 0, 0, 0,           1, 1, 1, 3, 'h33, 1};
    tv[5] = '{1, 0, 0, 0, 1, 0, 'hDEAD,      1, 1, 0, 0, 0, 0};
    tv[6] = '{1, 0, 0, 0, 0, 0, 0,           1, 1, 0, 0, 0, 2};
    tv[7] = '{1, 0, 0, 0, 0, 0, 0,           1, 1, 0, 0, 0, 0};
    bus.i_sys_ready = 0; bus.i_alu_valid = 0; bus.i_lsu_valid = 0;
    bus.i_alu_wr_id = '0; bus.i_alu_wr_data = '0; bus.i_lsu_wr_id = '0; bus.i_lsu_wr_data = '0;
    @(posedge clk);
    // Reset held two edges with both valids asserted.
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 1, 4, 'h44, 1, 6, 'h66);
      chk("rst_alu_ready", s_ar, 1);
      chk("rst_lsu_ready", s_lr, 1);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_wr_en", bus.o_wbu_gpr_wr_en, 0);
    end
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    chk("post_rst_no_write", bus.o_wbu_gpr_wr_en, 0);
    // Directed table: single ALU write, contested pair, write to x0.
    for (int i = 0; i < 8; i++) begin
      cyc(1, tv[i].rdy, tv[i].av, tv[i].aid, tv[i].ad, tv[i].lv, tv[i].lid, tv[i].ld);
      chk($sformatf("tv%0d_alu_ready", i), s_ar, tv[i].e_ar);
      chk($sformatf("tv%0d_lsu_ready", i), s_lr, tv[i].e_lr);
      chk($sformatf("tv%0d_en", i), bus.o_wbu_gpr_wr_en, tv[i].e_en);
      chk($sformatf("tv%0d_id", i), bus.o_wbu_gpr_wr_id, tv[i].e_id);
      chk($sformatf("tv%0d_data", i), bus.o_wbu_gpr_wr_data, tv[i].e_d);
      chk($sformatf("tv%0d_gnt", i), bus.o_arb_gnt, tv[i].e_g);
    end
    // Second contested pair: round-robin now favours ALU, fixed priority still LSU.
    cyc(1, 1, 1, 9, 'h99, 1, 10, 'hAA);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
`ifdef WBU_ARB_RR_EN
    chk("rr_first", bus.o_arb_gnt, GNT_ALU);
`else
    chk("fp_first", bus.o_arb_gnt, GNT_LSU);
`endif
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
`ifdef WBU_ARB_RR_EN
    chk("rr_second", bus.o_arb_gnt, GNT_LSU);
`else
    chk("fp_second", bus.o_arb_gnt, GNT_ALU);
`endif
    // Stall with both slots full.
    cyc(1, 0, 1, 11, 'hB1, 1, 12, 'hC2);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, 13, 'hD3, 1, 14, 'hE4);
      chk("stall_alu_ready", s_ar, 0);
      chk("stall_lsu_ready", s_lr, 0);
      chk("stall_busy", bus.o_busy, 1);
      chk("stall_no_write", bus.o_wbu_gpr_wr_en, 0);
    end
    writes = 0;
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 0, 0, 0, 0, 0, 0);
      writes += int'(bus.o_wbu_gpr_wr_en);
    end
    chk("stall_release_writes", writes, 2);
    // Streaming ALU ids 1..8 back to back.
    for (int i = 1; i <= 9; i++) begin
      cyc(1, 1, i <= 8, i, i * 16, 0, 0, 0);
      if (i <= 8) chk("stream_ready", s_ar, 1);
      if (i > 1) begin
        chk("stream_en", bus.o_wbu_gpr_wr_en, 1);
        chk("stream_id", bus.o_wbu_gpr_wr_id, i - 1);
      end
    end
    // Reset with both slots full discards them.
    cyc(1, 0, 1, 15, 'hF5, 1, 16, 'h16);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    chk("midrst_no_write", bus.o_wbu_gpr_wr_en, 0);
    chk("midrst_gnt", bus.o_arb_gnt, GNT_NONE);
    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(63) != 0, $urandom_range(3) != 0,
          $urandom_range(1) == 1, $urandom_range(31), $urandom,
          $urandom_range(1) == 1, $urandom_range(31), $urandom);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
